// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared constants and helpers for the AXI-Stream test blocks.
//   AXIS_DATA_W        default stream data width
//   LFSR_TAPS          tap mask of x^16+x^14+x^13+x^11+1 for a right-shifting
//                      Fibonacci LFSR (feedback enters bit 15)
//   LFSR_DEFAULT_SEED  default LFSR start value
//   lfsr16_next()      one LFSR step
//   lfsr16_fix_seed()  maps the lock-up seed 0 to 1
// -----------------------------------------------------------------------------
package axis_pkg;

    localparam int unsigned AXIS_DATA_W       = 32;
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;  // bits 0, 2, 3, 5
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    // An all-zero Fibonacci LFSR never leaves zero, so that seed is replaced.
    function automatic logic [15:0] lfsr16_fix_seed(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advancing every clock after
// reset. Loads the seed (0 replaced by 1) while rst_n is low.
//   clk    clock
//   rst_n  synchronous active-low reset
//   seed   value loaded during reset
//   state  current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import axis_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= lfsr16_fix_seed(seed);
        end else begin
            state <= lfsr16_next(state);
        end
    end

endmodule

// File: rtl/axis_consumer.sv
// -----------------------------------------------------------------------------
// axis_consumer
// AXI-Stream sink: generates a registered s_tready (constant or LFSR-throttled),
// accepts beats on valid&&ready and keeps statistics and sticky error flags.
//   clk, rst_n   clock, synchronous active-low reset
//   clr          synchronous statistics clear (ready/LFSR untouched)
//   s_tvalid     upstream valid
//   s_tdata      upstream data
//   s_tready     registered ready
//   beat_count   accepted beats (wraps)
//   data_sum     sum of accepted data (wraps)
//   last_data    most recently accepted data
//   stall_count  cycles with valid && !ready (saturates)
//   range_err    sticky: an accepted beat was >= RANGE_MAX
//   proto_err    sticky: a stalled beat was dropped or changed
// -----------------------------------------------------------------------------
module axis_consumer
    import axis_pkg::*;
#(
    parameter int unsigned DATA_W    = AXIS_DATA_W,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SUM_W     = 48,
    parameter bit          THROTTLE  = 1'b1,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter int unsigned RANGE_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              s_tready,
    output logic [CNT_W-1:0]  beat_count,
    output logic [SUM_W-1:0]  data_sum,
    output logic [DATA_W-1:0] last_data,
    output logic [CNT_W-1:0]  stall_count,
    output logic              range_err,
    output logic              proto_err
);

    // Range compare done wide enough that neither operand truncates.
    localparam int unsigned CMP_W = DATA_W + 32;

    logic [15:1] lfsr_unused;
    logic        lfsr_lsb;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .state ({lfsr_unused, lfsr_lsb})
    );

    // Upstream hold-rule tracking: a beat seen stalled last cycle and its data.
    logic              pend;
    logic [DATA_W-1:0] held;

    logic accept;
    logic stall;
    logic violation;
    logic out_of_range;

    assign accept       = s_tvalid && s_tready;
    assign stall        = s_tvalid && !s_tready;
    assign violation    = pend && (!s_tvalid || (s_tdata != held));
    assign out_of_range = CMP_W'(s_tdata) >= CMP_W'(RANGE_MAX);

    // Clear is applied first; events of the same cycle then land on the
    // cleared values.
    logic [CNT_W-1:0]  beat_base,  beat_next;
    logic [SUM_W-1:0]  sum_base,   sum_next;
    logic [CNT_W-1:0]  stall_base, stall_next;
    logic [DATA_W-1:0] last_next;
    logic              range_next, proto_next;

    always_comb begin
        // NOTE: each signal of this block is assigned on every path, so no
        // latch can be inferred.
        beat_base  = clr ? '0 : beat_count;
        sum_base   = clr ? '0 : data_sum;
        stall_base = clr ? '0 : stall_count;

        beat_next  = beat_base + CNT_W'(accept);
        sum_next   = sum_base + (accept ? SUM_W'(s_tdata) : '0);
        stall_next = (stall && (stall_base != '1)) ? stall_base + CNT_W'(1)
                                                   : stall_base;
        last_next  = accept ? s_tdata : (clr ? '0 : last_data);
        range_next = (range_err && !clr) | (accept && out_of_range);
        proto_next = (proto_err && !clr) | violation;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_tready    <= 1'b0;
            beat_count  <= '0;
            data_sum    <= '0;
            last_data   <= '0;
            stall_count <= '0;
            range_err   <= 1'b0;
            proto_err   <= 1'b0;
            pend        <= 1'b0;
            held        <= '0;
        end else begin
            s_tready    <= THROTTLE ? lfsr_lsb : 1'b1;
            beat_count  <= beat_next;
            data_sum    <= sum_next;
            last_data   <= last_next;
            stall_count <= stall_next;
            range_err   <= range_next;
            proto_err   <= proto_next;
            pend        <= stall && !clr;
            held        <= s_tdata;
        end
    end

endmodule

// File: tb/tb_axis_consumer.sv
// -----------------------------------------------------------------------------
// tb_axis_consumer
// Three instances: u0 unthrottled, u1 LFSR-throttled, u2 throttled with 4-bit
// counters. A transaction-level model per instance predicts every output and a
// single compare process checks all of them each cycle; directed phases add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_consumer;

    localparam int          N         = 3;
    localparam logic [63:0] SUM_MASK  = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [63:0] RANGE_MAX = 64'd4096;

    function automatic int cnt_bits(input int i);
        return (i == 2) ? 4 : 32;
    endfunction

    function automatic bit throttled(input int i);
        return (i != 0);
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        clr [N];
    logic        vld [N];
    logic [31:0] dat [N];

    initial forever #5 clk = ~clk;

    // DUT outputs
    logic        rdy0, rdy1, rdy2, rerr0, rerr1, rerr2, perr0, perr1, perr2;
    logic [31:0] bc0, bc1, stl0, stl1, last0, last1, last2;
    logic [3:0]  bc2, stl2;
    logic [47:0] sum0, sum1, sum2;

    axis_consumer #(.THROTTLE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .s_tvalid(vld[0]), .s_tdata(dat[0]),
        .s_tready(rdy0), .beat_count(bc0), .data_sum(sum0), .last_data(last0),
        .stall_count(stl0), .range_err(rerr0), .proto_err(perr0));

    axis_consumer #(.THROTTLE(1'b1), .LFSR_SEED(16'hACE1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .s_tvalid(vld[1]), .s_tdata(dat[1]),
        .s_tready(rdy1), .beat_count(bc1), .data_sum(sum1), .last_data(last1),
        .stall_count(stl1), .range_err(rerr1), .proto_err(perr1));

    axis_consumer #(.CNT_W(4), .THROTTLE(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]), .s_tvalid(vld[2]), .s_tdata(dat[2]),
        .s_tready(rdy2), .beat_count(bc2), .data_sum(sum2), .last_data(last2),
        .stall_count(stl2), .range_err(rerr2), .proto_err(perr2));

    // Random idle-gap / data source for the source side of u1.
    logic [15:0] gen_state;
    lfsr16 u_gen (.clk(clk), .rst_n(rst_n), .seed(16'h1234), .state(gen_state));

    logic        a_rdy [N], a_rerr [N], a_perr [N];
    logic [63:0] a_bc [N], a_sum [N], a_last [N], a_stl [N];

    assign a_rdy[0] = rdy0;  assign a_rdy[1] = rdy1;  assign a_rdy[2] = rdy2;
    assign a_rerr[0] = rerr0; assign a_rerr[1] = rerr1; assign a_rerr[2] = rerr2;
    assign a_perr[0] = perr0; assign a_perr[1] = perr1; assign a_perr[2] = perr2;
    assign a_bc[0] = 64'(bc0);     assign a_bc[1] = 64'(bc1);     assign a_bc[2] = 64'(bc2);
    assign a_sum[0] = 64'(sum0);   assign a_sum[1] = 64'(sum1);   assign a_sum[2] = 64'(sum2);
    assign a_last[0] = 64'(last0); assign a_last[1] = 64'(last1); assign a_last[2] = 64'(last2);
    assign a_stl[0] = 64'(stl0);   assign a_stl[1] = 64'(stl1);   assign a_stl[2] = 64'(stl2);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic        m_rdy [N], m_rerr [N], m_perr [N], m_pend [N];
    logic [15:0] m_lfsr [N];
    logic [31:0] m_held [N];
    logic [63:0] m_bc [N], m_sum [N], m_last [N], m_stl [N], m_raw_stl [N];

    task automatic model_reset(input int i);
        m_rdy[i] = 1'b0;  m_lfsr[i] = 16'hACE1;
        m_bc[i] = '0;     m_sum[i] = '0;   m_last[i] = '0;
        m_stl[i] = '0;    m_raw_stl[i] = '0;
        m_rerr[i] = 1'b0; m_perr[i] = 1'b0;
        m_pend[i] = 1'b0; m_held[i] = '0;
    endtask

    task automatic model_step(input int i);
        logic        acc, stl, viol;
        logic [63:0] lim;
        lim = (64'd1 << cnt_bits(i)) - 64'd1;
        if (!rst_n) begin
            model_reset(i);
        end else begin
            acc  = vld[i] && m_rdy[i];
            stl  = vld[i] && !m_rdy[i];
            viol = m_pend[i] && (!vld[i] || (dat[i] != m_held[i]));
            if (clr[i]) begin
                m_bc[i] = '0; m_sum[i] = '0; m_last[i] = '0;
                m_stl[i] = '0; m_raw_stl[i] = '0;
                m_rerr[i] = 1'b0; m_perr[i] = 1'b0;
            end
            if (acc) begin
                m_bc[i]   = (m_bc[i] + 64'd1) & lim;
                m_sum[i]  = (m_sum[i] + 64'(dat[i])) & SUM_MASK;
                m_last[i] = 64'(dat[i]);
                if (64'(dat[i]) >= RANGE_MAX) m_rerr[i] = 1'b1;
            end
            if (stl) begin
                m_raw_stl[i] = m_raw_stl[i] + 64'd1;
                if (m_stl[i] < lim) m_stl[i] = m_stl[i] + 64'd1;
            end
            if (viol) m_perr[i] = 1'b1;
            m_pend[i] = stl && !clr[i];
            m_held[i] = dat[i];
            m_rdy[i]  = throttled(i) ? m_lfsr[i][0] : 1'b1;
            m_lfsr[i] = {m_lfsr[i][0] ^ m_lfsr[i][2] ^ m_lfsr[i][3] ^ m_lfsr[i][5],
                         m_lfsr[i][15:1]};
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 1'b0;

    task automatic compare_inst(input int i);
        check($sformatf("u%0d.s_tready", i),    64'(a_rdy[i]),  64'(m_rdy[i]));
        check($sformatf("u%0d.beat_count", i),  a_bc[i],        m_bc[i]);
        check($sformatf("u%0d.data_sum", i),    a_sum[i],       m_sum[i]);
        check($sformatf("u%0d.last_data", i),   a_last[i],      m_last[i]);
        check($sformatf("u%0d.stall_count", i), a_stl[i],       m_stl[i]);
        check($sformatf("u%0d.range_err", i),   64'(a_rerr[i]), 64'(m_rerr[i]));
        check($sformatf("u%0d.proto_err", i),   64'(a_perr[i]), 64'(m_perr[i]));
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) for (int i = 0; i < N; i++) compare_inst(i);
    end

    // ---------------- stimulus helpers ----------------
    // Presents a beat and holds it (data stable) until the handshake edge has passed.
    task automatic send_beat(input int i, input logic [31:0] d);
        logic acc;
        int   n;
        n = 0;
        vld[i] = 1'b1;
        dat[i] = d;
        do begin
            acc = m_rdy[i];
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) check($sformatf("u%0d.beat_accept_timeout", i), 64'(acc), 64'd1);
    endtask

    task automatic wait_ready_low(input int i);
        int n;
        n = 0;
        while (m_rdy[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (m_rdy[i]) check($sformatf("u%0d.ready_low_timeout", i), 64'(m_rdy[i]), 64'd0);
    endtask

    task automatic pulse_clr(input int i);
        clr[i] = 1'b1;
        @(negedge clk);
        clr[i] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [4:0] ready_seq;
        int         n;
        ready_seq = 5'b10000;  // bit0 of ACE1, 5670, AB38, 559C, 2ACE
        for (int i = 0; i < N; i++) begin
            clr[i] = 1'b0; vld[i] = 1'b0; dat[i] = '0;
            model_reset(i);
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset.u1.s_tready",   64'(rdy1), 64'd0);
        check("reset.u0.beat_count", 64'(bc0),  64'd0);
        check("reset.u2.stall_count", 64'(stl2), 64'd0);

        // u1: valid held with stable data for 64 cycles straight out of reset.
        rst_n  = 1'b1;
        vld[1] = 1'b1;
        dat[1] = 32'd5;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k < 5) check($sformatf("u1.ready_seq[%0d]", k), 64'(rdy1), 64'(ready_seq[4-k]));
        end
        check("u1.beats_plus_stalls", a_bc[1] + a_stl[1], 64'd64);
        check("u1.proto_err_held",    64'(perr1), 64'd0);
        check("u1.last_data_held",    64'(last1), 64'd5);
        vld[1] = 1'b0;

        // u0: back-to-back beats.
        send_beat(0, 32'd10);
        send_beat(0, 32'd20);
        send_beat(0, 32'd30);
        send_beat(0, 32'd4095);
        vld[0] = 1'b0;
        check("u0.four_beats.count", 64'(bc0),   64'd4);
        check("u0.four_beats.sum",   64'(sum0),  64'd4155);
        check("u0.four_beats.last",  64'(last0), 64'd4095);
        check("u0.four_beats.rerr",  64'(rerr0), 64'd0);
        check("u0.four_beats.stall", 64'(stl0),  64'd0);

        send_beat(0, 32'd4096);
        vld[0] = 1'b0;
        check("u0.range_err_set", 64'(rerr0), 64'd1);
        send_beat(0, 32'd1);
        send_beat(0, 32'd2);
        vld[0] = 1'b0;
        check("u0.range_err_sticky", 64'(rerr0), 64'd1);
        pulse_clr(0);
        check("u0.clr.rerr",  64'(rerr0), 64'd0);
        check("u0.clr.count", 64'(bc0),   64'd0);

        for (int d = 1; d <= 5; d++) send_beat(0, 32'(d));
        clr[0] = 1'b1;
        send_beat(0, 32'd7);
        clr[0] = 1'b0;
        vld[0] = 1'b0;
        check("u0.clr_beat.count", 64'(bc0),   64'd1);
        check("u0.clr_beat.sum",   64'(sum0),  64'd7);
        check("u0.clr_beat.last",  64'(last0), 64'd7);

        // u1: hold-rule checks.
        pulse_clr(1);
        wait_ready_low(1);
        vld[1] = 1'b1; dat[1] = 32'd100;
        @(negedge clk);
        dat[1] = 32'd101;
        @(negedge clk);
        check("u1.proto_err_data_change", 64'(perr1), 64'd1);
        vld[1] = 1'b0;
        @(negedge clk);
        pulse_clr(1);
        check("u1.proto_err_cleared", 64'(perr1), 64'd0);

        wait_ready_low(1);
        send_beat(1, 32'd200);
        vld[1] = 1'b0;
        check("u1.proto_err_stable_stall", 64'(perr1), 64'd0);
        check("u1.stable_stall_last",      64'(last1), 64'd200);

        wait_ready_low(1);
        vld[1] = 1'b1; dat[1] = 32'd300;
        @(negedge clk);
        vld[1] = 1'b0;
        @(negedge clk);
        check("u1.proto_err_valid_drop", 64'(perr1), 64'd1);

        // u2: 4-bit counter wrap and stall saturation.
        pulse_clr(2);
        for (int d = 1; d <= 17; d++) send_beat(2, 32'(d));
        vld[2] = 1'b0;
        check("u2.beat_count_wrap", 64'(bc2), 64'd1);
        pulse_clr(2);
        vld[2] = 1'b1; dat[2] = 32'd9;
        n = 0;
        while (m_raw_stl[2] < 64'd20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("u2.stall_count_sat", 64'(stl2), 64'd15);
        send_beat(2, 32'd9);
        vld[2] = 1'b0;

        // u1: legal traffic with random idle gaps and data.
        for (int b = 0; b < 60; b++) begin
            if (gen_state[0]) begin
                vld[1] = 1'b0;
                @(negedge clk);
            end
            send_beat(1, 32'(gen_state));
        end
        vld[1] = 1'b0;

        // Reset asserted mid-burst with a beat presented.
        send_beat(0, 32'd40);
        send_beat(0, 32'd41);
        vld[0] = 1'b1; dat[0] = 32'd55;
        rst_n  = 1'b0;
        @(negedge clk);
        check("u0.midreset.ready", 64'(rdy0),  64'd0);
        check("u0.midreset.count", 64'(bc0),   64'd0);
        check("u0.midreset.sum",   64'(sum0),  64'd0);
        check("u0.midreset.last",  64'(last0), 64'd0);
        check("u0.midreset.rerr",  64'(rerr0), 64'd0);
        check("u1.midreset.perr",  64'(perr1), 64'd0);
        vld[0] = 1'b0;
        rst_n  = 1'b1;
        send_beat(0, 32'd3);
        vld[0] = 1'b0;
        check("u0.after_reset.count", 64'(bc0), 64'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_consumer.md
# axis_consumer

AXI-Stream slave sink that terminates a 32-bit stream from an upstream stream source in the `009_amba/axi_stream` test setup. It drives `s_tready` either constantly high or from an LFSR throttle pattern, and accepts beats on handshake. It accumulates statistics: beat count, data sum, last value and stall cycles. It flags out-of-range data and upstream protocol violations, where valid is dropped or data changes while stalled.

## Interface
Parameters:
- `DATA_W`, 32, stream data width
- `CNT_W`, 32, width of `beat_count` and `stall_count`
- `SUM_W`, 48, width of `data_sum`
- `THROTTLE`, 1, 0 = ready always high after reset, 1 = LFSR-driven ready
- `LFSR_SEED`, 16'hACE1, initial LFSR state (0 is replaced by 16'h0001)
- `RANGE_MAX`, 4096, accepted data must be < RANGE_MAX

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `clr`  in  1  synchronous statistics clear (does not touch LFSR/ready)
- `s_tvalid`  in  1  upstream valid
- `s_tdata`  in  DATA_W  upstream data
- `s_tready`  out  1  registered ready
- `beat_count`  out  CNT_W  accepted beats
- `data_sum`  out  SUM_W  sum of accepted data
- `last_data`  out  DATA_W  most recently accepted beat
- `stall_count`  out  CNT_W  cycles with `s_tvalid && !s_tready`
- `range_err`  out  1  sticky: an accepted beat was >= RANGE_MAX
- `proto_err`  out  1  sticky: upstream violated the hold rule

## Operation
- Handshake: a beat is accepted at a rising edge where `s_tvalid && s_tready`.
- Ready generation:
  - LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifted every cycle after reset.
  - THROTTLE=1: `s_tready <= lfsr[0]` each cycle.
  - THROTTLE=0: `s_tready <= 1`.
- On each accepted beat:
  - `beat_count += 1`, wrapping modulo 2^CNT_W.
  - `data_sum += zero-extended s_tdata`, wrapping modulo 2^SUM_W.
  - `last_data <= s_tdata`.
  - If `s_tdata >= RANGE_MAX`, set `range_err`.
- Stall: each cycle with `s_tvalid && !s_tready` increments `stall_count`, saturating at all-ones.
- Protocol check:
  - Register `pend = s_tvalid && !s_tready` and `held = s_tdata` every cycle.
  - If `pend` was 1 and the current cycle has `!s_tvalid` or `s_tdata != held`, set `proto_err`.
- `range_err` and `proto_err` are sticky until reset or `clr`.
- `clr` zeroes `beat_count`, `data_sum`, `last_data`, `stall_count`, `range_err`, `proto_err` and `pend`.
- `clr` coinciding with a handshake: clear has priority, then the beat is applied:
  - `beat_count=1`, `data_sum=data`, `last_data=data`, `range_err` per data.
  - A concurrent stall sets `stall_count=1`.

## Timing
- Reset values: `s_tready=0`, LFSR=seed, all statistics 0, both error flags 0, `pend=0`.
- `s_tready` first asserts no earlier than the first cycle after reset release; it never depends combinationally on `s_tvalid`.
- Statistics and flags update 1 cycle after the handshake or stall edge (registered outputs).
- Reset asserted mid-stream: all outputs return to reset values at that edge; a beat presented in the same cycle is not counted.
- Back-to-back beats at ready=1 are accepted every cycle, so throughput is 1 beat/clk with THROTTLE=0.
- `beat_count` wrap: from all-ones to 0 with no flag. `stall_count` holds at all-ones.

## Structure
- Shared package `axis_pkg`: `DATA_W` default, LFSR polynomial tap mask constant, default seed constant.
- One sub-module: `lfsr16` (clk, rst_n, seed, state), reused for ready generation and by the bench's random stall source.
- Statistics, protocol checker and ready register live in `axis_consumer`.

## Test plan
- THROTTLE=0, drive 4 beats 10, 20, 30, 4095 back-to-back -> `beat_count=4`, `data_sum=4155`, `last_data=4095`, `range_err=0`, `stall_count=0`.
- Accept one beat 4096 -> `range_err=1` one cycle later and stays 1 across further legal beats until `clr`.
- THROTTLE=1, seed 16'hACE1, hold `s_tvalid=1` for 64 cycles -> `s_tready` sequence matches the reference LFSR model bit-for-bit; `beat_count + stall_count = 64`.
- Hold a beat stalled with ready low, then change `s_tdata` (or drop `s_tvalid`) before the handshake -> `proto_err=1` next cycle. The same stall with stable data -> `proto_err=0`.
- Pulse `clr` in a handshake cycle with data 7 after 5 prior beats -> `beat_count=1`, `data_sum=7`, `last_data=7`.
- CNT_W=4, 17 beats -> `beat_count=1` (wrap). 20 stalled cycles -> `stall_count=15` (saturate). Assert `rst_n=0` mid-burst -> all outputs 0 next edge.
